// File: rtl/parall_pkg.sv
// parall_pkg: shared definitions for the parallel register bus master.
//   ADDR_W / DATA_W      bus address and data widths
//   DEF_*_CYC            default phase lengths in sclk cycles
//   state_t              sequencer state encoding (TURN exists only when
//                        PARALL_BUS_TURNAROUND_EN is defined)
//   cyc_load()           converts a phase length into a timer load value
package parall_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 8;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_TURN_CYC   = 2;

`ifdef PARALL_BUS_TURNAROUND_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;
`endif

  // A phase of N cycles is timed by loading N-1 into the down-counter and
  // leaving the phase when it reads zero. Lengths are clamped into 1..15 so
  // a zero parameter still yields a one-cycle phase.
  function automatic logic [3:0] cyc_load(input int cyc);
    if (cyc <= 1)       return 4'd0;
    else if (cyc >= 15) return 4'd14;
    else                return 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/parall_timer.sv
// parall_timer: 4-bit loadable down-counter shared by every bus phase.
//   sclk      clock
//   rst       synchronous active-high reset (count -> 0)
//   load      load load_val this cycle (has priority over counting)
//   load_val  value to load
//   zero      high while the count is zero; counting stops at zero
module parall_timer (
  input  logic       sclk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count_reg;

  always_ff @(posedge sclk) begin
    if (rst) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/parall_bus_master.sv
// parall_bus_master: master sequencer for the asynchronous 16-bit parallel
// register bus. Takes one read/write command at a time on a valid/ready port
// and runs a SETUP / STROBE / HOLD bus cycle with parameterised lengths.
//
// Optional feature macro: PARALL_BUS_TURNAROUND_EN
//   When defined, every read is followed by TURN_CYC idle-bus cycles (TURN
//   state) before a new command is accepted.
//
// Ports:
//   sclk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_wr                1 = write, 0 = read
//   cmd_addr, cmd_wdata   command address and write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             data of the last completed read
//   busy                  sequencer not idle
//   cs_n, rd_n, wr_n      active-low bus strobes
//   bus_addr              bus address
//   data_o, data_oe       write data and pad output enable
//   data_i                read data from the pad
module parall_bus_master
  import parall_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i
);

  localparam logic [3:0] SETUP_LD  = cyc_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = cyc_load(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = cyc_load(HOLD_CYC);
  localparam logic [3:0] TURN_LD   = cyc_load(TURN_CYC);

  state_t            state_reg;
  logic              wr_reg;
  logic              cs_n_reg;
  logic              rd_n_reg;
  logic              wr_n_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_o_reg;
  logic              data_oe_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic              tmr_load;
  logic [3:0]        tmr_val;
  logic              tmr_zero;

`ifndef PARALL_BUS_TURNAROUND_EN
  // Without the turnaround phase the TURN length has no consumer.
  logic unused_turn_ld;
  assign unused_turn_ld = ^TURN_LD;
`endif

  parall_timer u_timer (
    .sclk     (sclk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // The timer is reloaded on the same edge the FSM enters the next phase,
  // so the count reads zero exactly in the last cycle of each phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
`ifdef PARALL_BUS_TURNAROUND_EN
      ST_HOLD: begin
        if (tmr_zero && !wr_reg) begin
          tmr_load = 1'b1;
          tmr_val  = TURN_LD;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_reg        <= 1'b0;
      cs_n_reg      <= 1'b1;
      rd_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      addr_reg      <= '0;
      data_o_reg    <= '0;
      data_oe_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Bus pins are loaded here so they are valid from the first
            // SETUP cycle; data_oe is only ever raised for writes.
            state_reg   <= ST_SETUP;
            wr_reg      <= cmd_wr;
            cs_n_reg    <= 1'b0;
            addr_reg    <= cmd_addr;
            data_oe_reg <= cmd_wr;
            data_o_reg  <= cmd_wr ? cmd_wdata : '0;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            state_reg <= ST_STROBE;
            rd_n_reg  <= wr_reg;
            wr_n_reg  <= !wr_reg;
          end
        end
        ST_STROBE: begin
          if (tmr_zero) begin
            state_reg <= ST_HOLD;
            rd_n_reg  <= 1'b1;
            wr_n_reg  <= 1'b1;
            if (!wr_reg) begin
              rsp_rdata_reg <= data_i;
            end
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            cs_n_reg      <= 1'b1;
            addr_reg      <= '0;
            data_o_reg    <= '0;
            data_oe_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
`ifdef PARALL_BUS_TURNAROUND_EN
            state_reg     <= wr_reg ? ST_IDLE : ST_TURN;
`else
            state_reg     <= ST_IDLE;
`endif
          end
        end
`ifdef PARALL_BUS_TURNAROUND_EN
        ST_TURN: begin
          if (tmr_zero) begin
            state_reg <= ST_IDLE;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign cs_n      = cs_n_reg;
  assign rd_n      = rd_n_reg;
  assign wr_n      = wr_n_reg;
  assign bus_addr  = addr_reg;
  assign data_o    = data_o_reg;
  assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_parall_bus_master.sv
// tb_parall_bus_master: self-checking bench for parall_bus_master.
// A 32-register slave (addresses 0x00..0x1F, everything else unmapped and
// reading 0) sits on the bus; a second instance with SETUP_CYC=0 checks the
// clamp. Expected timing is derived from the phase lengths, expected data
// from a register-map model updated per command.
module tb_parall_bus_master;

  localparam int S   = 2;
  localparam int P   = 8;
  localparam int H   = 2;
  localparam int T   = 2;
  localparam int LAT = S + P + H + 1;
`ifdef PARALL_BUS_TURNAROUND_EN
  localparam int RD_GAP = 1 + T;
`else
  localparam int RD_GAP = 1;
`endif

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        cmd_ready, rsp_valid, busy, cs_n, rd_n, wr_n, data_oe;
  logic [15:0] rsp_rdata, data_o, data_i;
  logic [7:0]  bus_addr;

  logic        cmd_valid0 = 1'b0;
  logic        cmd_ready0, rsp_valid0, busy0, cs_n0, rd_n0, wr_n0, data_oe0;
  logic [15:0] rsp_rdata0, data_o0;
  logic [7:0]  bus_addr0;

  always #5 sclk = ~sclk;

  parall_bus_master #(.SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H), .TURN_CYC(T)) u_dut (
    .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .bus_addr(bus_addr),
    .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
  );

  parall_bus_master #(.SETUP_CYC(0), .STROBE_CYC(P), .HOLD_CYC(H), .TURN_CYC(T)) u_dut0 (
    .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0),
    .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .bus_addr(bus_addr0),
    .data_o(data_o0), .data_oe(data_oe0), .data_i(16'h0000)
  );

  // Bus slave: drives data while selected and reading, captures write data
  // when wr_n rises with cs_n still low.
  logic [15:0] slave_mem [0:31];
  int          slave_wr_cnt = 0;
  logic        prev_wr_n = 1'b1;

  assign data_i = (!cs_n && !rd_n && bus_addr < 8'd32) ? slave_mem[bus_addr[4:0]] : 16'h0000;

  always @(negedge sclk) begin
    if (prev_wr_n == 1'b0 && wr_n == 1'b1 && cs_n == 1'b0) begin
      slave_wr_cnt <= slave_wr_cnt + 1;
      if (bus_addr < 8'd32) slave_mem[bus_addr[4:0]] <= data_o;
    end
    prev_wr_n <= wr_n;
  end

  // Reference model of the register map.
  logic [15:0] exp_mem [0:31];
  bit          exp_known [0:31];
  logic [15:0] last_rd = 16'h0000;

  int n_checks = 0;
  int n_pass = 0;

  // Per-transaction observations
  int          o_cs_low, o_cs_first, o_stb_low, o_stb_first, o_other_low;
  int          o_oe_cnt, o_rsp_cnt, o_rsp_idx, o_conflict;
  logic [15:0] o_rdata;

  // Stream stimulus and trace
  logic        s_wr [0:7];
  logic [7:0]  s_addr [0:7];
  logic [15:0] s_wd [0:7];
  logic [15:0] s_rdata [0:7];
  int          s_rsp_n;
  logic        trace [0:255];
  int          trace_len;
  int          n_low_runs, n_gaps;
  int          gaps [0:7];

  task automatic model_apply(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                             output logic [15:0] exp_rd);
    exp_rd = 16'h0000;
    if (wr) begin
      if (addr < 8'd32) begin
        exp_mem[addr[4:0]] = wd;
        exp_known[addr[4:0]] = 1'b1;
      end
    end else begin
      exp_rd = (addr < 8'd32) ? exp_mem[addr[4:0]] : 16'h0000;
      last_rd = exp_rd;
    end
  endtask

  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [15:0] wd);
    int w;
    o_cs_low = 0; o_cs_first = 0; o_stb_low = 0; o_stb_first = 0; o_other_low = 0;
    o_oe_cnt = 0; o_rsp_cnt = 0; o_rsp_idx = 0; o_conflict = 0; o_rdata = 16'h0000;
    @(negedge sclk);
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge sclk);
      w++;
    end
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge sclk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sclk);
      if (!cs_n) begin o_cs_low++; if (o_cs_first == 0) o_cs_first = i; end
      if ((wr ? wr_n : rd_n) == 1'b0) begin o_stb_low++; if (o_stb_first == 0) o_stb_first = i; end
      if ((wr ? rd_n : wr_n) == 1'b0) o_other_low++;
      if (data_oe) o_oe_cnt++;
      if (!cs_n && data_oe && !wr) o_conflict++;
      if (rsp_valid) begin o_rsp_cnt++; o_rsp_idx = i; o_rdata = rsp_rdata; end
      if (o_rsp_cnt != 0 && i >= o_rsp_idx + 4) break;
    end
    $display("txn wr=%0b addr=%02h wdata=%04h rdata=%04h lat=%0d", wr, addr, wd, o_rdata, o_rsp_idx);
  endtask

  task automatic run_stream(input int n);
    int idx;
    logic acc;
    trace_len = 0; s_rsp_n = 0; idx = 0;
    @(negedge sclk);
    cmd_valid = 1'b1; cmd_wr = s_wr[0]; cmd_addr = s_addr[0]; cmd_wdata = s_wd[0];
    for (int cyc = 0; cyc < 200; cyc++) begin
      trace[cyc] = cs_n;
      trace_len = cyc + 1;
      if (rsp_valid && s_rsp_n < 8) begin
        s_rdata[s_rsp_n] = rsp_rdata;
        s_rsp_n++;
      end
      if (s_rsp_n >= n) break;
      acc = cmd_valid && cmd_ready;
      @(posedge sclk); #1;
      if (acc) begin
        idx++;
        if (idx < n) begin
          cmd_wr = s_wr[idx]; cmd_addr = s_addr[idx]; cmd_wdata = s_wd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge sclk);
    end
    cmd_valid = 1'b0;
    // Split the cs_n trace into low runs and the high gaps between them.
    n_low_runs = 0; n_gaps = 0;
    begin
      int run;
      logic in_low;
      run = 0; in_low = 1'b0;
      for (int i = 0; i < trace_len; i++) begin
        if (trace[i] == 1'b0) begin
          if (!in_low) begin
            if (n_low_runs > 0 && n_gaps < 8) begin gaps[n_gaps] = run; n_gaps++; end
            n_low_runs++;
            in_low = 1'b1;
          end
          run = 0;
        end else begin
          in_low = 1'b0;
          run++;
        end
      end
    end
    $display("stream n=%0d rsp=%0d cs_runs=%0d", n, s_rsp_n, n_low_runs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge sclk);
    #1;
    n_checks++; if (cs_n !== 1'b1 || rd_n !== 1'b1 || wr_n !== 1'b1) $display("FAIL reset_strobes: cs/rd/wr=%b%b%b want 111", cs_n, rd_n, wr_n); else n_pass++;
    n_checks++; if (data_oe !== 1'b0 || bus_addr !== 8'h00 || data_o !== 16'h0000) $display("FAIL reset_bus: oe=%b addr=%h data=%h want 0", data_oe, bus_addr, data_o); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || busy !== 1'b0) $display("FAIL reset_rsp: rv=%b rd=%h busy=%b want 0", rsp_valid, rsp_rdata, busy); else n_pass++;
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [15:0] e;
    model_apply(1'b1, 8'h03, 16'hA5C3, e);
    run_txn(1'b1, 8'h03, 16'hA5C3);
    n_checks++; if (o_stb_low != P) $display("FAIL wr_strobe_len: got %0d want %0d", o_stb_low, P); else n_pass++;
    n_checks++; if (o_stb_first != S + 1) $display("FAIL wr_strobe_start: got %0d want %0d", o_stb_first, S + 1); else n_pass++;
    n_checks++; if (o_cs_low != S + P + H || o_cs_first != 1) $display("FAIL wr_cs: len %0d first %0d want %0d/1", o_cs_low, o_cs_first, S + P + H); else n_pass++;
    n_checks++; if (o_oe_cnt != S + P + H) $display("FAIL wr_oe: got %0d want %0d", o_oe_cnt, S + P + H); else n_pass++;
    n_checks++; if (o_rsp_cnt != 1 || o_rsp_idx != LAT) $display("FAIL wr_rsp: cnt %0d at %0d want 1 at %0d", o_rsp_cnt, o_rsp_idx, LAT); else n_pass++;
    n_checks++; if (o_rdata !== 16'h0000) $display("FAIL wr_rdata_kept: got %h want 0000", o_rdata); else n_pass++;
    model_apply(1'b0, 8'h03, 16'h0000, e);
    run_txn(1'b0, 8'h03, 16'h0000);
    n_checks++; if (o_rdata !== 16'hA5C3) $display("FAIL rd_data: got %h want a5c3", o_rdata); else n_pass++;
    n_checks++; if (o_stb_low != P || o_other_low != 0) $display("FAIL rd_strobe: rd %0d wr %0d want %0d/0", o_stb_low, o_other_low, P); else n_pass++;
    n_checks++; if (o_oe_cnt != 0 || o_conflict != 0) $display("FAIL rd_oe: oe %0d conflict %0d want 0", o_oe_cnt, o_conflict); else n_pass++;
    n_checks++; if (o_rsp_cnt != 1 || o_rsp_idx != LAT) $display("FAIL rd_rsp: cnt %0d at %0d want 1 at %0d", o_rsp_cnt, o_rsp_idx, LAT); else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [15:0] e;
    model_apply(1'b0, 8'h20, 16'h0000, e);
    run_txn(1'b0, 8'h20, 16'h0000);
    n_checks++; if (o_rdata !== e) $display("FAIL unmapped_data: got %h want %h", o_rdata, e); else n_pass++;
    n_checks++; if (o_oe_cnt != 0) $display("FAIL unmapped_oe: got %0d want 0", o_oe_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wd, e, prev_rd;
    for (int n = 0; n < 16; n++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 63));
      wd = 16'($urandom);
      if (!wr && addr < 8'd32 && !exp_known[addr[4:0]]) wr = 1'b1;
      prev_rd = last_rd;
      model_apply(wr, addr, wd, e);
      run_txn(wr, addr, wd);
      n_checks++; if (o_rsp_cnt != 1 || o_rsp_idx != LAT) $display("FAIL rand_rsp[%0d]: cnt %0d at %0d want 1 at %0d", n, o_rsp_cnt, o_rsp_idx, LAT); else n_pass++;
      n_checks++; if (o_stb_low != P || o_other_low != 0) $display("FAIL rand_strobe[%0d]: got %0d/%0d want %0d/0", n, o_stb_low, o_other_low, P); else n_pass++;
      n_checks++; if (o_rdata !== (wr ? prev_rd : e)) $display("FAIL rand_rdata[%0d]: got %h want %h", n, o_rdata, wr ? prev_rd : e); else n_pass++;
      n_checks++; if (o_oe_cnt != (wr ? S + P + H : 0)) $display("FAIL rand_oe[%0d]: got %0d", n, o_oe_cnt); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int wc0;
    wc0 = slave_wr_cnt;
    for (int i = 0; i < 3; i++) begin
      s_wr[i] = 1'b1;
      s_addr[i] = 8'(8'h10 + i);
      s_wd[i] = 16'($urandom);
      model_apply(1'b1, s_addr[i], s_wd[i], e);
    end
    run_stream(3);
    n_checks++; if (s_rsp_n != 3 || n_low_runs != 3) $display("FAIL b2b_count: rsp %0d cs_runs %0d want 3/3", s_rsp_n, n_low_runs); else n_pass++;
    n_checks++; if (n_gaps != 2 || gaps[0] != 1 || gaps[1] != 1) $display("FAIL b2b_gap: n %0d g0 %0d g1 %0d want 2/1/1", n_gaps, gaps[0], gaps[1]); else n_pass++;
    n_checks++; if (slave_wr_cnt - wc0 != 3) $display("FAIL b2b_writes: got %0d want 3", slave_wr_cnt - wc0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (slave_mem[5'(16 + i)] !== exp_mem[5'(16 + i)]) $display("FAIL b2b_mem[%0d]: got %h want %h", i, slave_mem[5'(16 + i)], exp_mem[5'(16 + i)]); else n_pass++;
    end
  endtask

  task automatic test_turnaround();
    logic [15:0] e0, e;
    s_wr[0] = 1'b0; s_addr[0] = 8'h10; s_wd[0] = 16'h0000;
    model_apply(1'b0, 8'h10, 16'h0000, e0);
    for (int i = 1; i < 3; i++) begin
      s_wr[i] = 1'b1;
      s_addr[i] = 8'(8'h11 + i);
      s_wd[i] = 16'($urandom);
      model_apply(1'b1, s_addr[i], s_wd[i], e);
    end
    run_stream(3);
    n_checks++; if (s_rsp_n != 3 || s_rdata[0] !== e0) $display("FAIL turn_read: rsp %0d data %h want 3/%h", s_rsp_n, s_rdata[0], e0); else n_pass++;
    n_checks++; if (n_gaps != 2 || gaps[0] != RD_GAP) $display("FAIL turn_rd_wr_gap: got %0d want %0d", gaps[0], RD_GAP); else n_pass++;
    n_checks++; if (gaps[1] != 1) $display("FAIL turn_wr_wr_gap: got %0d want 1", gaps[1]); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [15:0] old, e;
    int wc0, rv;
    old = slave_mem[5];
    wc0 = slave_wr_cnt;
    @(negedge sclk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h05; cmd_wdata = ~old;
    @(posedge sclk); #1;
    cmd_valid = 1'b0;
    repeat (S + 4) @(negedge sclk);
    n_checks++; if (wr_n !== 1'b0) $display("FAIL abort_in_strobe: wr_n=%b want 0", wr_n); else n_pass++;
    rst = 1'b1;
    @(posedge sclk); #1;
    rst = 1'b0;
    last_rd = 16'h0000;
    n_checks++; if (cs_n !== 1'b1 || wr_n !== 1'b1 || data_oe !== 1'b0 || busy !== 1'b0) $display("FAIL abort_bus: cs=%b wr=%b oe=%b busy=%b want 1100", cs_n, wr_n, data_oe, busy); else n_pass++;
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      if (rsp_valid) rv++;
    end
    n_checks++; if (rv != 0) $display("FAIL abort_rsp: got %0d pulses want 0", rv); else n_pass++;
    n_checks++; if (slave_wr_cnt != wc0 || slave_mem[5] !== old) $display("FAIL abort_write: cnt %0d mem %h want %0d/%h", slave_wr_cnt, slave_mem[5], wc0, old); else n_pass++;
    model_apply(1'b1, 8'h06, 16'h3C5A, e);
    run_txn(1'b1, 8'h06, 16'h3C5A);
    model_apply(1'b0, 8'h06, 16'h0000, e);
    run_txn(1'b0, 8'h06, 16'h0000);
    n_checks++; if (o_rdata !== e || o_rsp_idx != LAT) $display("FAIL abort_recover: data %h at %0d want %h at %0d", o_rdata, o_rsp_idx, e, LAT); else n_pass++;
  endtask

  task automatic test_setup_clamp();
    int cs_first, stb_first, stb_low, rsp_idx;
    cs_first = 0; stb_first = 0; stb_low = 0; rsp_idx = 0;
    @(negedge sclk);
    cmd_valid0 = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h07; cmd_wdata = 16'h1234;
    @(posedge sclk); #1;
    cmd_valid0 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sclk);
      if (!cs_n0 && cs_first == 0) cs_first = i;
      if (!wr_n0) begin stb_low++; if (stb_first == 0) stb_first = i; end
      if (rsp_valid0 && rsp_idx == 0) rsp_idx = i;
    end
    $display("txn setup0 wr addr=07 cs_first=%0d stb_first=%0d lat=%0d", cs_first, stb_first, rsp_idx);
    n_checks++; if (cs_first != 1 || stb_first != 2) $display("FAIL clamp_setup: cs %0d strobe %0d want 1/2", cs_first, stb_first); else n_pass++;
    n_checks++; if (stb_low != P || rsp_idx != 1 + P + H + 1) $display("FAIL clamp_timing: strobe %0d lat %0d want %0d/%0d", stb_low, rsp_idx, P, 1 + P + H + 1); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = 16'h0000;
      exp_known[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_unmapped();
    test_random();
    test_back_to_back();
    test_turnaround();
    test_reset_abort();
    test_setup_clamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
